debounced_onehot_encoder: RTL

//  Parametrised, clocked successor of the combinational one-hot-to-BCD switch encoder.

---
 rtl/enc_pkg.sv | 38 +++
 rtl/switch_synchronizer.sv | 30 +++
 rtl/debounced_onehot_encoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared types and helpers for the debounced switch encoder.
// The helpers work on a fixed-width vector. Callers zero-extend narrower switch vectors to that width.
package enc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        PRESSED = 3'd2,
        REL_DEB = 3'd3,
        ERROR   = 3'd4
    } enc_state_e;

    localparam int MODE_STRICT   = 0;
    localparam int MODE_PRIORITY = 1;

    // Upper bound on N_SW supported by the helpers below.
    localparam int MAX_SW  = 64;
    localparam int INDEX_W = 7;

    function automatic logic [INDEX_W-1:0] lowest_index(input logic [MAX_SW-1:0] vec);
        logic [INDEX_W-1:0] idx;
        logic               found;
        idx   = 7'd0;
        found = 1'b0;
        for (int i = 0; i < MAX_SW; i++) begin
            if (vec[i] && !found) begin
                idx   = INDEX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [MAX_SW-1:0] vec);
        return (vec != {MAX_SW{1'b0}}) && ((vec & (vec - 64'd1)) == {MAX_SW{1'b0}});
    endfunction

endpackage

// File: rtl/switch_synchronizer.sv
// Per-bit flop chain that brings raw asynchronous switch levels into the clk domain.
module switch_synchronizer #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the raw levels through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= raw;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign synced = stage_r[STAGES-1];

endmodule

// File: rtl/debounced_onehot_encoder.sv
// Synchronises and debounces switch inputs, then encodes the accepted pattern.
// Outputs are registered codes plus press/release event pulses.
module debounced_onehot_encoder
    import enc_pkg::*;
#(
    parameter int N_SW        = 10,
    parameter int CODE_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int MODE        = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SW-1:0]   switch,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              idle,
    output logic              multi_err,
    output logic              press_pulse,
    output logic              release_pulse
);

    localparam int              CNT_W      = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [N_SW-1:0]    sync_s;
    logic [N_SW-1:0]    cand_r;
    logic [N_SW-1:0]    acc_r;
    logic [CNT_W-1:0]   cnt_r;
    enc_state_e         state_r;

    logic [MAX_SW-1:0]  cand_ext_s;
    logic [INDEX_W-1:0] low_idx_s;
    logic [CODE_W-1:0]  cand_code_s;
    logic               cand_zero_s;
    logic               cand_legal_s;

    switch_synchronizer #(
        .WIDTH  (N_SW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (switch),
        .synced (sync_s)
    );

    // Classify the candidate pattern. The candidate equals the synchronised vector whenever it is accepted.
    always_comb begin
        cand_ext_s  = MAX_SW'(cand_r);
        low_idx_s   = lowest_index(cand_ext_s);
        cand_code_s = CODE_W'(low_idx_s);
        cand_zero_s = (cand_r == {N_SW{1'b0}});
        if (MODE == MODE_PRIORITY) begin
            cand_legal_s = !cand_zero_s;
        end else begin
            cand_legal_s = is_onehot(cand_ext_s);
        end
    end

    // Debounce FSM with registered outputs. Pulses default low and fire only on an accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cand_r        <= '0;
            acc_r         <= '0;
            cnt_r         <= '0;
            code          <= '0;
            valid         <= 1'b0;
            idle          <= 1'b1;
            multi_err     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state_r)
                IDLE, PRESSED, ERROR: begin
                    if (sync_s != acc_r) begin
                        cand_r  <= sync_s;
                        cnt_r   <= CNT_ONE;
                        state_r <= (state_r == PRESSED) ? REL_DEB : SETTLE;
                    end
                end
                SETTLE, REL_DEB: begin
                    if (sync_s == acc_r) begin
                        // Glitch back to the stable pattern: resume the prior state silently.
                        cnt_r <= '0;
                        if (state_r == REL_DEB) begin
                            state_r <= PRESSED;
                        end else if (acc_r == {N_SW{1'b0}}) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= ERROR;
                        end
                    end else if (sync_s != cand_r) begin
                        cand_r <= sync_s;
                        cnt_r  <= CNT_ONE;
                    end else if (cnt_r == CNT_ACCEPT) begin
                        acc_r         <= cand_r;
                        cnt_r         <= '0;
                        release_pulse <= (state_r == REL_DEB);
                        if (cand_zero_s) begin
                            state_r   <= IDLE;
                            code      <= '0;
                            valid     <= 1'b0;
                            idle      <= 1'b1;
                            multi_err <= 1'b0;
                        end else if (cand_legal_s) begin
                            state_r     <= PRESSED;
                            code        <= cand_code_s;
                            valid       <= 1'b1;
                            idle        <= 1'b0;
                            multi_err   <= 1'b0;
                            press_pulse <= 1'b1;
                        end else begin
                            state_r   <= ERROR;
                            code      <= '0;
                            valid     <= 1'b0;
                            idle      <= 1'b0;
                            multi_err <= 1'b1;
                        end
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    acc_r     <= '0;
                    cnt_r     <= '0;
                    code      <= '0;
                    valid     <= 1'b0;
                    idle      <= 1'b1;
                    multi_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
